// File: rtl/pipe_sequencer.sv
// pipe_sequencer
// Pipeline-level controller between the hazard unit and the F/D/E/M/W
// pipeline registers of the dual ARM/RISC-V core. It merges the hazard
// unit's stall/flush requests with two sequenced events: multi-cycle
// execute ops (iterative mul/div) that freeze F/D/E until done, and ISA
// mode switches that drain the pipeline before the arm mode bit toggles.
//
// Ports:
//   clk, reset_n                 core clock, asynchronous active-low reset
//   hz_stall_f/_d, hz_flush_d/_e hazard unit requests
//   mc_start_e, mc_done          multi-cycle op valid in E / result ready
//   mode_req_valid, mode_req     mode change request (held until mode_ack)
//   en_f..en_w                   pipeline register enables
//   flush_d/_e/_m                synchronous clears of the D/E/M registers
//   arm                          current ISA mode (1 = ARM), registered
//   mode_ack                     one-cycle pulse on the cycle arm updates
//   mc_busy                      high while waiting on a multi-cycle op
//   mc_timeout_err               sticky timeout flag, cleared by reset only
//   state                        debug: RUN=0, MCWAIT=1, DRAIN=2, SWITCH=3
module pipe_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MC_TIMEOUT   = 64,
  parameter bit ARM_RESET    = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hz_stall_f,
  input  logic       hz_stall_d,
  input  logic       hz_flush_d,
  input  logic       hz_flush_e,
  input  logic       mc_start_e,
  input  logic       mc_done,
  input  logic       mode_req_valid,
  input  logic       mode_req,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       en_m,
  output logic       en_w,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       arm,
  output logic       mode_ack,
  output logic       mc_busy,
  output logic       mc_timeout_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    MCWAIT = 2'd1,
    DRAIN  = 2'd2,
    SWITCH = 2'd3
  } state_e;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] MC_LAST    = 8'(MC_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       arm_q, arm_d;
  logic       target_q, target_d;
  logic [3:0] drainCnt_q, drainCnt_d;
  logic [7:0] mcCnt_q, mcCnt_d;
  logic       mcErr_q, mcErr_d;

  logic mcEnter;
  logic mcFinish;
  logic switchReq;

  // A flushed mul/div is squashed, so it never starts a wait.
  assign mcEnter   = (state_q == RUN) && mc_start_e && !hz_flush_e;
  // Release on the result or on timeout; >= guards a saturated counter.
  assign mcFinish  = (state_q == MCWAIT) && (mc_done || (mcCnt_q >= MC_LAST));
  // A mul/div start takes priority over a mode switch in the same cycle.
  assign switchReq = mode_req_valid && (mode_req != arm_q) && !mc_start_e;

  // State register plus the sequencing counters, mode bit and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      arm_q      <= ARM_RESET;
      target_q   <= ARM_RESET;
      drainCnt_q <= 4'd0;
      mcCnt_q    <= 8'd0;
      mcErr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      target_q   <= target_d;
      drainCnt_q <= drainCnt_d;
      mcCnt_q    <= mcCnt_d;
      mcErr_q    <= mcErr_d;
    end
  end

  // Next-state logic; counters saturate rather than wrap.
  always_comb begin
    state_d    = state_q;
    arm_d      = arm_q;
    target_d   = target_q;
    drainCnt_d = drainCnt_q;
    mcCnt_d    = mcCnt_q;
    mcErr_d    = mcErr_q;
    unique case (state_q)
      RUN: begin
        if (mcEnter) begin
          state_d = MCWAIT;
          mcCnt_d = 8'd0;
        end else if (switchReq) begin
          state_d    = DRAIN;
          target_d   = mode_req;
          drainCnt_d = 4'd0;
        end
      end
      MCWAIT: begin
        if (mcCnt_q != 8'hFF) mcCnt_d = mcCnt_q + 8'd1;
        if (mc_done) begin
          state_d = RUN;
        end else if (mcCnt_q >= MC_LAST) begin
          state_d = RUN;
          mcErr_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drainCnt_q != 4'hF) drainCnt_d = drainCnt_q + 4'd1;
        if (drainCnt_q >= DRAIN_LAST) state_d = SWITCH;
      end
      SWITCH: begin
        arm_d   = target_q;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic: RUN rules by default, overridden per state.
  always_comb begin
    en_f     = !hz_stall_f;
    en_d     = !hz_stall_d;
    en_e     = 1'b1;
    en_m     = 1'b1;
    en_w     = 1'b1;
    flush_d  = hz_flush_d;
    flush_e  = hz_flush_e;
    flush_m  = 1'b0;
    mode_ack = 1'b0;
    mc_busy  = 1'b0;
    unique case (state_q)
      RUN: begin
        // Hold the op in E and push a bubble into M.
        if (mcEnter) begin
          en_f    = 1'b0;
          en_d    = 1'b0;
          en_e    = 1'b0;
          flush_m = 1'b1;
        end
      end
      MCWAIT: begin
        mc_busy = 1'b1;
        // On the release cycle E advances with normal RUN outputs.
        if (!mcFinish) begin
          en_f    = 1'b0;
          en_d    = 1'b0;
          en_e    = 1'b0;
          flush_d = 1'b0;
          flush_e = 1'b0;
          flush_m = 1'b1;
        end
      end
      DRAIN, SWITCH: begin
        // Fetch frozen and D flushed so only bubbles follow; stalls ignored.
        en_f     = 1'b0;
        en_d     = 1'b1;
        flush_d  = 1'b1;
        flush_e  = hz_flush_e;
        mode_ack = (state_q == SWITCH);
      end
      default: ;
    endcase
  end

  assign arm            = arm_q;
  assign mc_timeout_err = mcErr_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb_pipe_sequencer
// Directed bench for pipe_sequencer (DRAIN_CYCLES=4, MC_TIMEOUT=8,
// ARM_RESET=0). Inputs change just after the falling edge; outputs are
// compared one time unit later, well away from the rising edge.
module tb_pipe_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hz_stall_f = 1'b0;
  logic hz_stall_d = 1'b0;
  logic hz_flush_d = 1'b0;
  logic hz_flush_e = 1'b0;
  logic mc_start_e = 1'b0;
  logic mc_done = 1'b0;
  logic mode_req_valid = 1'b0;
  logic mode_req = 1'b0;
  logic en_f, en_d, en_e, en_m, en_w;
  logic flush_d, flush_e, flush_m;
  logic arm, mode_ack, mc_busy, mc_timeout_err;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_sequencer #(
    .DRAIN_CYCLES(4),
    .MC_TIMEOUT  (8),
    .ARM_RESET   (1'b0)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hz_stall_f    (hz_stall_f),
    .hz_stall_d    (hz_stall_d),
    .hz_flush_d    (hz_flush_d),
    .hz_flush_e    (hz_flush_e),
    .mc_start_e    (mc_start_e),
    .mc_done       (mc_done),
    .mode_req_valid(mode_req_valid),
    .mode_req      (mode_req),
    .en_f          (en_f),
    .en_d          (en_d),
    .en_e          (en_e),
    .en_m          (en_m),
    .en_w          (en_w),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .flush_m       (flush_m),
    .arm           (arm),
    .mode_ack      (mode_ack),
    .mc_busy       (mc_busy),
    .mc_timeout_err(mc_timeout_err),
    .state         (state)
  );

  // Drive one cycle's inputs after the falling edge, then settle.
  task automatic applyStimulus(input logic sf, input logic sd, input logic fd,
                               input logic fe, input logic mcs, input logic mcd,
                               input logic mrv, input logic mr);
    @(negedge clk);
    hz_stall_f     = sf;
    hz_stall_d     = sd;
    hz_flush_d     = fd;
    hz_flush_e     = fe;
    mc_start_e     = mcs;
    mc_done        = mcd;
    mode_req_valid = mrv;
    mode_req       = mr;
    #1;
  endtask

  // Compare every output against hand-computed values.
  // expEn = {f,d,e,m,w}, expFl = {d,e,m}.
  task automatic checkOutput(input string tag, input logic [4:0] expEn,
                             input logic [2:0] expFl, input logic expAck,
                             input logic expBusy, input logic expErr,
                             input logic expArm, input logic [1:0] expSt);
    logic [13:0] obs;
    logic [13:0] expv;
    obs  = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, flush_m,
            mode_ack, mc_busy, mc_timeout_err, arm, state};
    expv = {expEn, expFl, expAck, expBusy, expErr, expArm, expSt};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%04h expected=%04h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset held: RUN outputs with idle hazards, arm = ARM_RESET.
    #12;
    checkOutput("resetHeld", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // RUN passes hazard requests straight through.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("runStallF", 5'b01111, 3'b100, 0, 0, 0, 0, 2'd0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    checkOutput("runStallD", 5'b10111, 3'b010, 0, 0, 0, 0, 2'd0);

    // Multi-cycle op: entry cycle, four wait cycles, done cycle.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("mcEnter", 5'b00011, 3'b001, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mcWait", 5'b00011, 3'b001, 0, 1, 0, 0, 2'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mcDone", 5'b11111, 3'b000, 0, 1, 0, 0, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("mcDoneStray", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("afterStray", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);

    // Flushed multi-cycle start is squashed.
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    checkOutput("mcSquash", 5'b11111, 3'b010, 0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mcSquashNext", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);

    // Mode switch 0 -> 1: request cycle, 4 drain cycles, switch.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("modeReq", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("drain0", 5'b01111, 3'b100, 0, 0, 0, 0, 2'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain1Drop", 5'b01111, 3'b100, 0, 0, 0, 0, 2'd2);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("drain2Stall", 5'b01111, 3'b100, 0, 0, 0, 0, 2'd2);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("drain3FlushE", 5'b01111, 3'b110, 0, 0, 0, 0, 2'd2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("switch", 5'b01111, 3'b100, 1, 0, 0, 0, 2'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("armSet", 5'b11111, 3'b000, 0, 0, 0, 1, 2'd0);

    // Request for the current mode does nothing.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("sameMode", 5'b11111, 3'b000, 0, 0, 0, 1, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("sameModeHold", 5'b11111, 3'b000, 0, 0, 0, 1, 2'd0);

    // Timeout: 8 wait cycles, release on the 8th, sticky error.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("toEnter", 5'b00011, 3'b001, 0, 0, 0, 1, 2'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("toWait", 5'b00011, 3'b001, 0, 1, 0, 1, 2'd1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("toRelease", 5'b11111, 3'b000, 0, 1, 0, 1, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("toErrSet", 5'b11111, 3'b000, 0, 0, 1, 1, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("toErrSticky", 5'b11111, 3'b000, 0, 0, 1, 1, 2'd0);

    // Reset in the middle of a wait clears state, arm and the error.
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("rstEnter", 5'b00011, 3'b001, 0, 0, 1, 1, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstWait", 5'b00011, 3'b001, 0, 1, 1, 1, 2'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rstRelease", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);

    // Mode request and mul/div start together: wait first, then switch.
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 1);
    checkOutput("bothEnter", 5'b00011, 3'b001, 0, 0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("bothWait", 5'b00011, 3'b001, 0, 1, 0, 0, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    checkOutput("bothDone", 5'b11111, 3'b000, 0, 1, 0, 0, 2'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("bothRun", 5'b11111, 3'b000, 0, 0, 0, 0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("bothDrain", 5'b01111, 3'b100, 0, 0, 0, 0, 2'd2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("bothSwitch", 5'b01111, 3'b100, 1, 0, 0, 0, 2'd3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bothArm", 5'b11111, 3'b000, 0, 0, 0, 1, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
Name: pipe_sequencer

Overview:
- Pipeline-level controller that sits between the hazard unit and the F/D/E/M/W pipeline registers of the dual ARM/RISC-V core.
- Combines the hazard unit's stall/flush requests with two sequenced events:
  - multi-cycle execute ops (iterative mul/div) that freeze F/D/E until done;
  - ISA mode switches, which drain the pipeline before the `arm` mode bit toggles.
- Owns the registered `arm` signal consumed by the hazard unit and decoders.

Parameters:
- DRAIN_CYCLES, 4, cycles of bubble injection before a mode switch (pipeline depth minus 1); legal range 1..15.
- MC_TIMEOUT, 64, max MCWAIT cycles before forced release; legal range 2..255.
- ARM_RESET, 0, value of `arm` after reset (0 = RISC-V, 1 = ARM).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- hz_stall_f  in  1  StallF from hazard unit
- hz_stall_d  in  1  StallD from hazard unit
- hz_flush_d  in  1  FlushD from hazard unit
- hz_flush_e  in  1  FlushE from hazard unit
- mc_start_e  in  1  multi-cycle op is valid in E this cycle
- mc_done  in  1  mul/div result ready (single-cycle pulse)
- mode_req_valid  in  1  mode change requested; held until mode_ack
- mode_req  in  1  requested mode (1 = ARM)
- en_f, en_d, en_e, en_m, en_w  out  1 each  pipeline register enables
- flush_d, flush_e, flush_m  out  1 each  synchronous clears of the D/E/M registers
- arm  out  1  current ISA mode (registered)
- mode_ack  out  1  one-cycle pulse on the cycle `arm` is updated
- mc_busy  out  1  high while in MCWAIT
- mc_timeout_err  out  1  sticky; set on timeout, cleared only by reset
- state  out  2  debug: RUN=0, MCWAIT=1, DRAIN=2, SWITCH=3

Behaviour:
- Reset (asynchronous):
  - state=RUN, arm=ARM_RESET, counters=0, mc_timeout_err=0.
  - mode_ack=0 and mc_busy=0 while reset is held.
  - Enables and flushes are combinational from state and inputs; in RUN they follow the RUN rules below.
  - Reset asserted mid-MCWAIT or mid-DRAIN aborts the sequence; no mode_ack is issued.
- RUN:
  - en_f=~hz_stall_f, en_d=~hz_stall_d, en_e=en_m=en_w=1.
  - flush_d=hz_flush_d, flush_e=hz_flush_e, flush_m=0.
- RUN -> MCWAIT when mc_start_e & ~hz_flush_e.
  - A flushed mul/div op is squashed; no wait is entered.
  - In that same cycle: en_f=en_d=en_e=0, flush_m=1, so the op stays in E and a bubble enters M.
  - The timeout counter is cleared.
- MCWAIT:
  - en_f=en_d=en_e=0, en_m=en_w=1, flush_m=1, flush_d=flush_e=0, mc_busy=1.
  - The counter increments each cycle.
  - mc_done: that cycle uses RUN outputs (E advances, flush_m=0); next state RUN.
  - Counter reaches MC_TIMEOUT-1 without mc_done: set mc_timeout_err, use RUN outputs that cycle, next state RUN.
- RUN -> DRAIN when mode_req_valid & (mode_req != arm) & ~mc_start_e.
  - A mul/div start has priority; the switch is taken later.
  - The target mode is latched and the drain counter cleared.
- DRAIN:
  - en_f=0, flush_d=1, en_d=en_e=en_m=en_w=1, flush_e=hz_flush_e, flush_m=0.
  - Hazard stalls are ignored.
  - Counter increments; at DRAIN_CYCLES-1, next state SWITCH.
  - Deasserting mode_req_valid during DRAIN does not abort; the latched target is used.
- SWITCH (exactly 1 cycle):
  - en_f=0, flush_d=1, other stages enabled, mode_ack=1.
  - arm <= latched target at the end of the cycle; next state RUN.
- Boundary cases:
  - mode_req_valid with mode_req==arm: no action, no ack.
  - mc_start_e in DRAIN/SWITCH is impossible by construction (F is frozen and D flushed); ignore it.
  - mc_done outside MCWAIT is ignored.
- Counters: 4-bit drain counter, 8-bit timeout counter; both saturate and never wrap.

Test Plan:
- Reset with reset_n=0 mid-MCWAIT -> state=0, arm=ARM_RESET, mc_busy=0; after release, en_*=1 and flushes=0 with idle hazard inputs.
- mc_start_e=1 at cycle 10, mc_done at cycle 15 -> mc_busy high cycles 11-15; en_e=0 cycles 10-14, en_e=1 cycle 15; flush_m=1 cycles 10-14.
- mc_start_e and hz_flush_e both 1 -> stays in RUN, flush_e=1, mc_busy never asserts.
- From arm=0, raise mode_req_valid=1, mode_req=1 with DRAIN_CYCLES=4 -> flush_d=1 for 5 cycles; mode_ack pulses in cycle 5; arm=1 the following cycle; en_f returns to 1.
- mc_start_e with mc_done never asserted, MC_TIMEOUT=8 -> release after 8 cycles; mc_timeout_err=1 and stays 1 until reset.
- mode_req_valid and mc_start_e in the same cycle -> MCWAIT first; after mc_done, DRAIN starts the next cycle and the switch completes.
